// File: rtl/bus_seq_key.sv
// bus_seq_key: bus-sequenced key. A programmed sequence of qualified reads
// unlocks the block. While unlocked, each read returns LFSR response bits.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_LOCKED   | idle, waiting for step 0 pattern; LFSR held at seed
// S_SEQ      | step_q patterns matched so far (1..STEPS-1)
// S_UNLOCKED | key open; reads return LFSR bits and advance the LFSR
module bus_seq_key #(
  parameter int                  AW          = 4,
  parameter int                  STEPS       = 4,
  parameter logic [STEPS*AW-1:0] SEQ         = 16'hAB92,
  parameter logic [AW-1:0]       LOCK_CODE   = 4'hF,
  parameter int                  LFSR_W      = 6,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS   = 6'h30,
  parameter logic [LFSR_W-1:0]   LFSR_SEED   = 6'h01,
  parameter int                  DW          = 1,
  parameter logic [DW-1:0]       LOCK_PAT    = 1'b0,
  parameter int                  READ_BUDGET = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bus_stb,
  input  logic          sser,
  input  logic          win,
  input  logic          br_w,
  input  logic [AW-1:0] ba_fld,
  output logic [DW-1:0] dout,
  output logic          dout_oe,
  output logic          unlocked,
  output logic [3:0]    step
);

  localparam int CW = (READ_BUDGET == 0) ? 1 : $clog2(READ_BUDGET + 1);

  typedef enum logic [1:0] {S_LOCKED, S_SEQ, S_UNLOCKED} state_t;

  state_t              state_q, state_d;
  logic [3:0]          step_q, step_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       cnt_inc;
  logic                acc, rd, wr;

  // Step k pattern; k never reaches STEPS because the sequencer unlocks first.
  function automatic logic [AW-1:0] pat(input logic [3:0] i);
    return SEQ[int'(i)*AW +: AW];
  endfunction

  assign acc     = bus_stb & ~sser & win;
  assign rd      = acc & br_w;
  assign wr      = acc & ~br_w;
  assign cnt_inc = cnt_q + 1'b1;

  assign unlocked = (state_q == S_UNLOCKED);
  assign step     = (state_q == S_SEQ) ? step_q : 4'd0;
  assign dout     = unlocked ? lfsr_q[LFSR_W-1 -: DW] : LOCK_PAT;
  assign dout_oe  = rd;

  // State, step index, LFSR and read counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOCKED;
      step_q  <= 4'd0;
      lfsr_q  <= LFSR_SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: write beats relock code beats budget beats pattern match.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    if (wr) begin
      state_d = S_LOCKED;
    end else if (rd) begin
      case (state_q)
        S_LOCKED: begin
          if (ba_fld == pat(4'd0)) begin
            if (STEPS == 1) begin
              state_d = S_UNLOCKED;
            end else begin
              state_d = S_SEQ;
              step_d  = 4'd1;
            end
          end
        end
        S_SEQ: begin
          if (ba_fld == pat(step_q)) begin
            if (step_q == 4'(STEPS - 1)) begin
              state_d = S_UNLOCKED;
              step_d  = 4'd0;
            end else begin
              step_d = step_q + 4'd1;
            end
          end else if (ba_fld == pat(4'd0)) begin
            step_d = 4'd1;
          end else begin
            state_d = S_LOCKED;
          end
        end
        S_UNLOCKED: begin
          if (ba_fld == LOCK_CODE) begin
            state_d = S_LOCKED;
          end else if ((READ_BUDGET != 0) && (cnt_inc == CW'(READ_BUDGET))) begin
            state_d = S_LOCKED;
          end else begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
            cnt_d  = cnt_inc;
          end
        end
        default: state_d = S_LOCKED;
      endcase
    end
    // Every entry into LOCKED restarts the response stream from the seed.
    if (state_d == S_LOCKED) begin
      step_d = 4'd0;
      lfsr_d = LFSR_SEED;
      cnt_d  = '0;
    end
  end

endmodule

// File: tb/tb_bus_seq_key.sv
// Testbench for bus_seq_key: default instance (a) and a budget-limited
// instance (b, READ_BUDGET=2, LOCK_PAT=1) share one bus.
module tb_bus_seq_key;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bus_stb = 1'b0;
  logic       sser = 1'b1;
  logic       win = 1'b0;
  logic       br_w = 1'b1;
  logic [3:0] ba_fld = 4'h0;

  logic       dout_a, dout_oe_a, unlocked_a;
  logic [3:0] step_a;
  logic       dout_b, dout_oe_b, unlocked_b;
  logic [3:0] step_b;

  int errors = 0;
  int checks = 0;

  logic exp_a[$];
  logic exp_b[$];

  always #5 clk = ~clk;

  bus_seq_key dut_a (
    .clk(clk), .rst_n(rst_n), .bus_stb(bus_stb), .sser(sser), .win(win),
    .br_w(br_w), .ba_fld(ba_fld), .dout(dout_a), .dout_oe(dout_oe_a),
    .unlocked(unlocked_a), .step(step_a)
  );

  bus_seq_key #(.READ_BUDGET(2), .LOCK_PAT(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus_stb(bus_stb), .sser(sser), .win(win),
    .br_w(br_w), .ba_fld(ba_fld), .dout(dout_b), .dout_oe(dout_oe_b),
    .unlocked(unlocked_b), .step(step_b)
  );

  // One bus access; pending scoreboard entries are compared against dout.
  task automatic bus(input logic is_rd, input logic [3:0] fld,
                     input logic s, input logic w);
    logic e;
    logic oe_exp;
    @(negedge clk);
    bus_stb = 1'b1; br_w = is_rd; ba_fld = fld; sser = s; win = w;
    oe_exp = is_rd & ~s & w;
    #1;
    checks++;
    if (dout_oe_a !== oe_exp) begin
      errors++;
      $display("FAIL oe_a fld=%h got=%b exp=%b", fld, dout_oe_a, oe_exp);
    end
    checks++;
    if (dout_oe_b !== oe_exp) begin
      errors++;
      $display("FAIL oe_b fld=%h got=%b exp=%b", fld, dout_oe_b, oe_exp);
    end
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      checks++;
      if (dout_a !== e) begin
        errors++;
        $display("FAIL dout_a fld=%h got=%b exp=%b", fld, dout_a, e);
      end
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      checks++;
      if (dout_b !== e) begin
        errors++;
        $display("FAIL dout_b fld=%h got=%b exp=%b", fld, dout_b, e);
      end
    end
    @(posedge clk);
    #1;
    bus_stb = 1'b0; sser = 1'b1; win = 1'b0;
  endtask

  task automatic rd(input logic [3:0] fld);
    bus(1'b1, fld, 1'b0, 1'b1);
  endtask

  task automatic wr(input logic [3:0] fld);
    bus(1'b0, fld, 1'b0, 1'b1);
  endtask

  task automatic chk_a(input string name, input logic u, input logic [3:0] s);
    checks++;
    if (unlocked_a !== u || step_a !== s) begin
      errors++;
      $display("FAIL %s_a got unlocked=%b step=%0d exp unlocked=%b step=%0d",
               name, unlocked_a, step_a, u, s);
    end
  endtask

  task automatic chk_b(input string name, input logic u, input logic [3:0] s);
    checks++;
    if (unlocked_b !== u || step_b !== s) begin
      errors++;
      $display("FAIL %s_b got unlocked=%b step=%0d exp unlocked=%b step=%0d",
               name, unlocked_b, step_b, u, s);
    end
  endtask

  task automatic unlock_seq();
    rd(4'h2); rd(4'h9); rd(4'hB); rd(4'hA);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (dout_a !== 1'b0 || dout_oe_a !== 1'b0 || dout_b !== 1'b1 || dout_oe_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_dout got a=%b/%b b=%b/%b exp a=0/0 b=1/0",
               dout_a, dout_oe_a, dout_b, dout_oe_b);
    end
    chk_a("reset", 1'b0, 4'd0);
    chk_b("reset", 1'b0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unlock();
    logic [3:0] flds[4] = '{4'h2, 4'h9, 4'hB, 4'hA};
    logic [3:0] steps[4] = '{4'd1, 4'd2, 4'd3, 4'd0};
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(1'b0);
      rd(flds[i]);
      chk_a("unlock_step", (i == 3), steps[i]);
    end
  endtask

  task automatic test_lfsr();
    logic exp[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      exp_a.push_back(exp[i]);
      rd(4'h0);
    end
    chk_a("lfsr_still_unlocked", 1'b1, 4'd0);
  endtask

  task automatic test_restart();
    logic [3:0] flds[6] = '{4'h2, 4'h9, 4'h2, 4'h9, 4'hB, 4'hA};
    logic [3:0] steps[6] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd3, 4'd0};
    wr(4'h0);
    chk_a("restart_relock", 1'b0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      rd(flds[i]);
      chk_a("restart_step", (i == 5), steps[i]);
    end
    wr(4'h0);
    rd(4'h2); chk_a("bad_seq1", 1'b0, 4'd1);
    rd(4'h9); chk_a("bad_seq2", 1'b0, 4'd2);
    rd(4'h5); chk_a("bad_seq3", 1'b0, 4'd0);
  endtask

  task automatic test_write_relock();
    logic exp[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    unlock_seq();
    rd(4'h0); rd(4'h0); rd(4'h0);
    wr(4'h0);
    chk_a("write_relock", 1'b0, 4'd0);
    unlock_seq();
    // Reseeded stream: bit 5 first rises on the 6th read.
    for (int i = 0; i < 6; i++) begin
      exp_a.push_back(exp[i]);
      rd(4'h0);
    end
    wr(4'h0);
  endtask

  task automatic test_lock_code();
    logic exp[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    unlock_seq();
    rd(4'h0); rd(4'h0);
    exp_a.push_back(1'b0);
    rd(4'hF);
    chk_a("lock_code", 1'b0, 4'd0);
    unlock_seq();
    for (int i = 0; i < 6; i++) begin
      exp_a.push_back(exp[i]);
      rd(4'h0);
    end
    wr(4'h0);
  endtask

  task automatic test_budget();
    wr(4'h0);
    exp_b.push_back(1'b1); exp_b.push_back(1'b1);
    exp_b.push_back(1'b1); exp_b.push_back(1'b1);
    unlock_seq();
    chk_b("budget_unlock", 1'b1, 4'd0);
    exp_b.push_back(1'b0);
    rd(4'h0);
    chk_b("budget_rd1", 1'b1, 4'd0);
    exp_b.push_back(1'b0);
    rd(4'h0);
    chk_b("budget_rd2", 1'b0, 4'd0);
    exp_b.push_back(1'b1);
    rd(4'h0);
    chk_b("budget_rd3", 1'b0, 4'd0);
    unlock_seq();
    exp_b.push_back(1'b0);
    rd(4'hF);
    chk_b("budget_lock_code", 1'b0, 4'd0);
  endtask

  task automatic test_async_reset();
    wr(4'h0);
    rd(4'h2); rd(4'h9);
    chk_a("async_pre", 1'b0, 4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst", 1'b0, 4'd0);
    #1;
    rst_n = 1'b1;
    unlock_seq();
    chk_a("async_unlock", 1'b1, 4'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_a("async_rst_unl", 1'b0, 4'd0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_qualify();
    bus(1'b1, 4'h2, 1'b1, 1'b1);
    chk_a("qual_sser", 1'b0, 4'd0);
    bus(1'b1, 4'h2, 1'b0, 1'b0);
    chk_a("qual_win", 1'b0, 4'd0);
    rd(4'h2);
    chk_a("qual_seq1", 1'b0, 4'd1);
    bus(1'b0, 4'h0, 1'b1, 1'b1);
    chk_a("qual_wr_sser", 1'b0, 4'd1);
    bus(1'b0, 4'h0, 1'b0, 1'b0);
    chk_a("qual_wr_win", 1'b0, 4'd1);
    rd(4'h9);
    chk_a("qual_seq2", 1'b0, 4'd2);
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_lfsr();
    test_restart();
    test_write_relock();
    test_lock_code();
    test_budget();
    test_async_reset();
    test_qualify();
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got a=%0d b=%0d exp 0", exp_a.size(), exp_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
